// File: rtl/water_inlet_arbiter.sv
// Round-robin arbiter for a shared water inlet across 4 machines: grants last at most QUANTUM cycles,
// then a GAP-cycle valve-settle interval. All outputs are registered and hold pauses the active grant.
module water_inlet_arbiter #(
  parameter int QUANTUM = 10,
  parameter int GAP     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       hold,
  output logic [3:0] grant,
  output logic [1:0] owner,
  output logic       valve_open,
  output logic       busy,
  output logic       expired
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  localparam logic [3:0] CNT_LAST = 4'(QUANTUM - 1);
  localparam logic [1:0] GAP_LAST = 2'(GAP - 1);

  logic [1:0] state_q, state_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] owner_q, owner_d;
  logic       valve_q, valve_d;
  logic       busy_q, busy_d;
  logic       expired_q, expired_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] gap_q, gap_d;
  logic [1:0] last_q, last_d;

  logic       win_vld;
  logic [1:0] win_idx;
  logic [1:0] cand;

  // Scan starts one past the previous owner so every requester is served in turn.
  always_comb begin
    win_vld = 1'b0;
    win_idx = last_q;
    cand    = last_q;
    for (int i = 1; i <= 4; i++) begin
      cand = last_q + 2'(i);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    last_d    = last_q;
    expired_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        grant_d = 4'b0000;
        if (win_vld && !hold) begin
          state_d = S_GRANT;
          grant_d = 4'b0001 << win_idx;
          owner_d = win_idx;
          cnt_d   = 4'd0;
        end
      end
      S_GRANT: begin
        // A dropped request wins over hold and over quantum exhaustion, and never flags expiry.
        if (!req[owner_q] || (!hold && cnt_q == CNT_LAST)) begin
          state_d   = S_GAP;
          grant_d   = 4'b0000;
          last_d    = owner_q;
          gap_d     = 2'd0;
          expired_d = req[owner_q];
        end else if (!hold) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_GAP: begin
        grant_d = 4'b0000;
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 2'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = 4'b0000;
      end
    endcase
    valve_d = (state_d == S_GRANT) && !hold;
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      grant_q   <= 4'b0000;
      owner_q   <= 2'd0;
      valve_q   <= 1'b0;
      busy_q    <= 1'b0;
      expired_q <= 1'b0;
      cnt_q     <= 4'd0;
      gap_q     <= 2'd0;
      last_q    <= 2'd3;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      valve_q   <= valve_d;
      busy_q    <= busy_d;
      expired_q <= expired_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      last_q    <= last_d;
    end
  end

  assign grant      = grant_q;
  assign owner      = owner_q;
  assign valve_open = valve_q;
  assign busy       = busy_q;
  assign expired    = expired_q;

endmodule

// File: tb/tb_water_inlet_arbiter.sv
// Vector-table bench for water_inlet_arbiter (QUANTUM=10, GAP=2): inputs per edge with hand-derived expected outputs.
module tb_water_inlet_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic       hold;
  logic [3:0] grant;
  logic [1:0] owner;
  logic       valve_open;
  logic       busy;
  logic       expired;

  water_inlet_arbiter #(.QUANTUM(10), .GAP(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .hold       (hold),
    .grant      (grant),
    .owner      (owner),
    .valve_open (valve_open),
    .busy       (busy),
    .expired    (expired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] owner;
    logic       valve;
    logic       busy;
    logic       expired;
  } out_t;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       hold;
    out_t       exp;
  } vec_t;

  vec_t vecs[$];
  out_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic add(input int n, input logic rst, input logic [3:0] rq, input logic hd,
                     input logic [3:0] g, input logic [1:0] o, input logic v, input logic b,
                     input logic e);
    vec_t t;
    t.rst = rst; t.req = rq; t.hold = hd;
    t.exp = '{grant: g, owner: o, valve: v, busy: b, expired: e};
    for (int k = 0; k < n; k++) vecs.push_back(t);
  endtask

  // One full-quantum grant to `own`, then the expired cycle, one GAP cycle, and the GAP->IDLE cycle.
  task automatic add_full(input logic [3:0] rq, input logic [1:0] own);
    logic [3:0] oh;
    oh = 4'b0001 << own;
    add(10, 1'b0, rq, 1'b0, oh, own, 1'b1, 1'b1, 1'b0);
    add(1, 1'b0, rq, 1'b0, 4'b0000, own, 1'b0, 1'b1, 1'b1);
    add(1, 1'b0, rq, 1'b0, 4'b0000, own, 1'b0, 1'b1, 1'b0);
    add(1, 1'b0, rq, 1'b0, 4'b0000, own, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check(input string name, input int idx, input out_t got, input out_t want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s vec=%0d got grant=%b owner=%0d valve=%b busy=%b expired=%b want grant=%b owner=%0d valve=%b busy=%b expired=%b",
                  name, idx, got.grant, got.owner, got.valve, got.busy, got.expired,
                  want.grant, want.owner, want.valve, want.busy, want.expired);
  endtask

  initial begin
    out_t got;
    out_t want;
    reset = 1'b1; req = 4'b0000; hold = 1'b0;

    // Single requester: full quantum, expiry, gap, regrant, then a drop at counter 3
    // while another machine requests only during GAP (must not be latched).
    add(2, 1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    add_full(4'b0001, 2'd0);
    add(4, 1'b0, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0);
    add(2, 1'b0, 4'b0010, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0);
    add(1, 1'b0, 4'b0010, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    add(1, 1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

    // All requesting: round-robin 0,1,2,3,0.
    add(1, 1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    add_full(4'b1111, 2'd0);
    add_full(4'b1111, 2'd1);
    add_full(4'b1111, 2'd2);
    add_full(4'b1111, 2'd3);
    add(1, 1'b0, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0);

    // Hold for 3 edges at counter 4 stretches the grant to 13 cycles; hold during GAP/IDLE;
    // then a req drop under hold releases without expiry.
    add(1, 1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    add(5, 1'b0, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0);
    add(3, 1'b0, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b0, 1'b1, 1'b0);
    add(5, 1'b0, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0);
    add(1, 1'b0, 4'b0001, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b1);
    add(1, 1'b0, 4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0);
    add(2, 1'b0, 4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    add(1, 1'b0, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0);
    add(1, 1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0);
    add(1, 1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0);
    add(1, 1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

    // Reset mid-grant of owner 3 restores req[0] priority; reset at the exhaustion edge gives no expiry.
    add(1, 1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    add(2, 1'b0, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b1, 1'b0);
    add(1, 1'b1, 4'b1001, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    add(10, 1'b0, 4'b1001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0);
    add(1, 1'b1, 4'b1001, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    add(1, 1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset = vecs[i].rst;
      req   = vecs[i].req;
      hold  = vecs[i].hold;
      sb.push_back(vecs[i].exp);
      @(posedge clk);
      #1;
      got  = '{grant: grant, owner: owner, valve: valve_open, busy: busy, expired: expired};
      want = sb.pop_front();
      check("vector", i, got, want);
      n_checks++;
      if ($countones(grant) <= 1 && (!valve_open || grant != 4'b0000)) n_pass++;
      else $display("FAIL invariant vec=%0d got grant=%b valve=%b want onehot0 grant and valve->grant",
                    i, grant, valve_open);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
